// File: rtl/pwm_reg_master.sv
// Host-side initiator for the PWM register file: single commands over valid/ready
// plus a built-in program/verify/enable init sequence.
module pwm_reg_master #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [3:0]       cmd_addr,
   input  logic [WIDTH-1:0] cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   input  logic             init_start,
   input  logic [WIDTH-1:0] init_period,
   input  logic [WIDTH-1:0] init_duty,
   input  logic [WIDTH-1:0] init_presc,
   input  logic             init_mode,
   output logic             init_busy,
   output logic             init_done,
   output logic             init_fail,
   output logic             wr_en,
   output logic             rd_en,
   output logic [3:0]       addr,
   output logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] rd_data
);

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_PERIOD = 4'h4;
   localparam logic [3:0] ADDR_DUTY   = 4'h8;
   localparam logic [3:0] ADDR_PRESC  = 4'hC;

   typedef enum logic [2:0] {IDLE, BUS, RESP, INIT_SEQ, INIT_END} state_e;

   state_e           state_q, state_d;
   logic [2:0]       step_q, step_d;
   logic             fail_q, fail_d;
   logic             run_q;
   logic [WIDTH-1:0] period_q, period_d, duty_q, duty_d, presc_q, presc_d;
   logic             mode_q, mode_d;
   logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic [3:0]       addr_q, addr_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;
   logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0] rd_exp;

   // run_q keeps cmd_ready low while reset is asserted and until the first clock after it.
   assign cmd_ready = run_q && (state_q == IDLE) && !init_start;
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign init_busy = (state_q == INIT_SEQ);
   assign init_done = (state_q == INIT_END);
   assign init_fail = init_done && fail_q;
   assign wr_en     = wr_en_q;
   assign rd_en     = rd_en_q;
   assign addr      = addr_q;
   assign wr_data   = wr_data_q;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      fail_d      = fail_q;
      period_d    = period_q;
      duty_d      = duty_q;
      presc_d     = presc_q;
      mode_d      = mode_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      addr_d      = '0;
      wr_data_d   = '0;

      unique case (addr_q)
         ADDR_PERIOD: rd_exp = period_q;
         ADDR_DUTY:   rd_exp = duty_q;
         ADDR_PRESC:  rd_exp = presc_q;
         default:     rd_exp = '0;
      endcase

      unique case (state_q)
         IDLE: begin
            if (init_start) begin
               period_d = init_period;
               duty_d   = init_duty;
               presc_d  = init_presc;
               mode_d   = init_mode;
               step_d   = '0;
               fail_d   = 1'b0;
               if (init_duty > init_period) begin
                  state_d = INIT_END;
                  fail_d  = 1'b1;
               end else begin
                  state_d = INIT_SEQ;
                  wr_en_d = 1'b1;
                  addr_d  = ADDR_CTRL;
               end
            end else if (cmd_valid && cmd_ready) begin
               rsp_rdata_d = '0;
               if (cmd_addr[1:0] == 2'b00) begin
                  state_d   = BUS;
                  rsp_err_d = 1'b0;
                  wr_en_d   = cmd_write;
                  rd_en_d   = !cmd_write;
                  addr_d    = cmd_addr;
                  wr_data_d = cmd_write ? cmd_wdata : '0;
               end else begin
                  state_d   = RESP;
                  rsp_err_d = 1'b1;
               end
            end
         end
         BUS: begin
            if (rd_en_q) rsp_rdata_d = rd_data;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         INIT_SEQ: begin
            // The compare feeds fail_d directly so the last readback can still veto the enable.
            if (rd_en_q && (rd_data != rd_exp)) fail_d = 1'b1;
            if (step_q == 3'd7) begin
               state_d = INIT_END;
            end else begin
               step_d = step_q + 3'd1;
               unique case (step_d)
                  3'd1: begin wr_en_d = 1'b1; addr_d = ADDR_PRESC;  wr_data_d = presc_q;  end
                  3'd2: begin wr_en_d = 1'b1; addr_d = ADDR_PERIOD; wr_data_d = period_q; end
                  3'd3: begin wr_en_d = 1'b1; addr_d = ADDR_DUTY;   wr_data_d = duty_q;   end
                  3'd4: begin rd_en_d = 1'b1; addr_d = ADDR_PERIOD; end
                  3'd5: begin rd_en_d = 1'b1; addr_d = ADDR_DUTY;   end
                  3'd6: begin rd_en_d = 1'b1; addr_d = ADDR_PRESC;  end
                  default: begin
                     if (!fail_d) begin
                        wr_en_d   = 1'b1;
                        addr_d    = ADDR_CTRL;
                        wr_data_d = {{(WIDTH-2){1'b0}}, mode_q, 1'b1};
                     end
                  end
               endcase
            end
         end
         INIT_END: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         step_q      <= '0;
         fail_q      <= 1'b0;
         run_q       <= 1'b0;
         period_q    <= '0;
         duty_q      <= '0;
         presc_q     <= '0;
         mode_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         fail_q      <= fail_d;
         run_q       <= 1'b1;
         period_q    <= period_d;
         duty_q      <= duty_d;
         presc_q     <= presc_d;
         mode_q      <= mode_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_pwm_reg_master.sv
// Scoreboard bench for pwm_reg_master: expected bus accesses, responses and init
// results are queued by the stimulus and popped by negedge monitors.
module tb_pwm_reg_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [3:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_rdata;
   logic        init_start, init_mode, init_busy, init_done, init_fail;
   logic [15:0] init_period, init_duty, init_presc;
   logic        wr_en, rd_en;
   logic [3:0]  addr;
   logic [15:0] wr_data, rd_data;

   typedef struct packed {logic we; logic [3:0] a; logic [15:0] d;} bus_t;
   typedef struct packed {logic err; logic [15:0] rd;} rsp_t;

   bus_t bus_q[$];
   rsp_t rsp_q[$];
   logic init_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // PWM register-file model; corrupt flips bit 0 of duty readback.
   logic [15:0] m_ctrl = '0, m_period = '0, m_duty = '0, m_presc = '0;
   logic        corrupt = 1'b0;

   always #5 clk = ~clk;

   pwm_reg_master #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .init_start(init_start), .init_period(init_period), .init_duty(init_duty),
      .init_presc(init_presc), .init_mode(init_mode),
      .init_busy(init_busy), .init_done(init_done), .init_fail(init_fail),
      .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
   );

   always @(posedge clk) begin
      if (wr_en) begin
         case (addr)
            4'h0: m_ctrl   <= wr_data;
            4'h4: m_period <= wr_data;
            4'h8: m_duty   <= wr_data;
            4'hC: m_presc  <= wr_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (addr)
            4'h0: rd_data = m_ctrl;
            4'h4: rd_data = m_period;
            4'h8: rd_data = corrupt ? (m_duty ^ 16'h0001) : m_duty;
            4'hC: rd_data = m_presc;
            default: rd_data = '0;
         endcase
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: bus strobes, responses and init completions against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en || rd_en) begin
            check("single_strobe", {wr_en, rd_en} == 2'b11, 0);
            if (bus_q.size() == 0) begin
               check("unexpected_strobe", {wr_en, addr, wr_data}, 0);
               check("unexpected_strobe_flag", 1, 0);
            end else begin
               bus_t e;
               e = bus_q.pop_front();
               check("bus_we", wr_en, e.we);
               check("bus_addr", addr, e.a);
               if (e.we) check("bus_wdata", wr_data, e.d);
            end
         end else begin
            check("idle_bus_zero", {addr, wr_data}, 0);
         end
         if (init_busy) check("no_rsp_in_init", rsp_valid, 0);
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               check("rsp_err", rsp_err, r.err);
               check("rsp_rdata", rsp_rdata, r.rd);
            end
         end
         if (init_done) begin
            if (init_q.size() == 0) check("unexpected_init_done", 1, 0);
            else check("init_fail", init_fail, init_q.pop_front());
         end
      end
   end

   task automatic exp_bus(input logic we, input logic [3:0] a, input logic [15:0] d);
      bus_t e;
      e.we = we; e.a = a; e.d = d;
      bus_q.push_back(e);
   endtask

   task automatic do_cmd(input logic wr, input logic [3:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input logic exp_err, input int hold);
      int   t;
      rsp_t r;
      r.err = exp_err; r.rd = exp_rd;
      rsp_q.push_back(r);
      if (!exp_err) exp_bus(wr, a, d);
      rsp_ready = (hold == 0);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("accept_latency", t, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      @(negedge clk);
      if (exp_err) begin
         check("err_rsp_n1", rsp_valid, 1);
         check("err_no_strobe", wr_en | rd_en, 0);
      end else begin
         check("strobe_n1", wr ? wr_en : rd_en, 1);
         check("no_rsp_n1", rsp_valid, 0);
         @(negedge clk);
         check("rsp_n2", rsp_valid, 1);
      end
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", rsp_valid, 1);
         check("hold_rdata", rsp_rdata, exp_rd);
         check("hold_cmd_ready", cmd_ready, 0);
         @(posedge clk); #1;
         if (i == hold - 1) rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
   endtask

   // Returns at S+1 (just after edge S); cmd_valid is raised alongside to test priority.
   task automatic start_init(input logic [15:0] per, input logic [15:0] duty,
                             input logic [15:0] presc, input logic mode);
      init_period = per; init_duty = duty; init_presc = presc; init_mode = mode;
      init_start = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
      @(negedge clk);
      check("init_priority_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
      init_start = 1'b0; cmd_valid = 1'b0; cmd_addr = '0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {cmd_ready, rsp_valid, rsp_err, init_busy, init_done, init_fail,
                   wr_en, rd_en, addr, wr_data, rsp_rdata}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1; init_start = 1'b0; init_mode = 1'b0;
      init_period = '0; init_duty = '0; init_presc = '0;
      #3;
      check_all_zero("reset_outputs");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic write/read, illegal address, back-pressured read.
      do_cmd(1'b1, 4'h4, 16'h03E8, 16'h0000, 1'b0, 0);
      do_cmd(1'b0, 4'h4, 16'h0000, 16'h03E8, 1'b0, 0);
      do_cmd(1'b0, 4'h6, 16'h0000, 16'h0000, 1'b1, 0);
      do_cmd(1'b1, 4'h8, 16'h00FA, 16'h0000, 1'b0, 0);
      do_cmd(1'b0, 4'h8, 16'h0000, 16'h00FA, 1'b0, 5);
      do_cmd(1'b1, 4'hC, 16'h0007, 16'h0000, 1'b0, 0);

      // Successful init: period=1000, duty=250, presc=4, mode=1.
      exp_bus(1'b1, 4'h0, 16'h0000);
      exp_bus(1'b1, 4'hC, 16'h0004);
      exp_bus(1'b1, 4'h4, 16'h03E8);
      exp_bus(1'b1, 4'h8, 16'h00FA);
      exp_bus(1'b0, 4'h4, 16'h0000);
      exp_bus(1'b0, 4'h8, 16'h0000);
      exp_bus(1'b0, 4'hC, 16'h0000);
      exp_bus(1'b1, 4'h0, 16'h0003);
      init_q.push_back(1'b0);
      start_init(16'd1000, 16'd250, 16'd4, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("init_busy", init_busy, 1);
         check("init_strobe", wr_en | rd_en, 1);
      end
      @(negedge clk);
      check("init_done_s9", init_done, 1);
      check("init_busy_s9", init_busy, 0);
      check("model_en", m_ctrl[0], 1);
      check("model_mode", m_ctrl[1], 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("init_done_pulse", init_done, 0);
      @(posedge clk); #1;

      // Range failure: duty > period.
      init_q.push_back(1'b1);
      start_init(16'd1000, 16'd1200, 16'd4, 1'b1);
      @(negedge clk);
      check("range_done_s1", init_done, 1);
      check("range_fail_s1", init_fail, 1);
      check("range_no_busy", init_busy, 0);
      @(posedge clk); #1;

      // Corrupted duty readback: no final enable write.
      corrupt = 1'b1;
      exp_bus(1'b1, 4'h0, 16'h0000);
      exp_bus(1'b1, 4'hC, 16'h0004);
      exp_bus(1'b1, 4'h4, 16'h03E8);
      exp_bus(1'b1, 4'h8, 16'h00FA);
      exp_bus(1'b0, 4'h4, 16'h0000);
      exp_bus(1'b0, 4'h8, 16'h0000);
      exp_bus(1'b0, 4'hC, 16'h0000);
      init_q.push_back(1'b1);
      start_init(16'd1000, 16'd250, 16'd4, 1'b1);
      repeat (7) @(negedge clk);
      @(negedge clk);
      check("corrupt_busy_s8", init_busy, 1);
      check("corrupt_no_enable", wr_en | rd_en, 0);
      @(negedge clk);
      check("corrupt_done_s9", init_done, 1);
      check("corrupt_ctrl_off", m_ctrl, 0);
      @(posedge clk); #1;
      corrupt = 1'b0;

      // Reset in the middle of init at S+5.
      exp_bus(1'b1, 4'h0, 16'h0000);
      exp_bus(1'b1, 4'hC, 16'h0005);
      exp_bus(1'b1, 4'h4, 16'h0064);
      exp_bus(1'b1, 4'h8, 16'h0032);
      start_init(16'd100, 16'd50, 16'd5, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset_outputs");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset_cmd_ready", cmd_ready, 1);
      check("post_reset_idle", {init_busy, init_done, rsp_valid}, 0);
      @(posedge clk); #1;
      do_cmd(1'b0, 4'hC, 16'h0000, 16'h0005, 1'b0, 0);

      repeat (3) @(negedge clk);
      check("bus_q_empty", bus_q.size(), 0);
      check("rsp_q_empty", rsp_q.size(), 0);
      check("init_q_empty", init_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_reg_master.md
Name: pwm_reg_master

Overview:
Bus initiator that drives the PWM register-file interface (wr_en/rd_en/addr/wr_data/rd_data) from the host side. It accepts single register commands over a valid/ready channel and returns a response for each one. It also runs a built-in init sequence that programs prescaler, period and duty, reads them back to verify, then enables the PWM. It sits between the host/CPU command path and the PWM register block.

Parameters:
WIDTH, 16, data width of the register bus and all data ports

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
cmd_valid  input  1  host command valid
cmd_ready  output  1  high when a command can be accepted
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  4  register address
cmd_wdata  input  WIDTH  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_rdata  output  WIDTH  read data; 0 for writes and errors
rsp_err  output  1  illegal address
init_start  input  1  one-cycle pulse that starts the init sequence
init_period  input  WIDTH  period value for init
init_duty  input  WIDTH  duty value for init
init_presc  input  WIDTH  prescaler value for init
init_mode  input  1  mode bit for init
init_busy  output  1  init sequence in progress
init_done  output  1  one-cycle pulse at the end of the sequence
init_fail  output  1  qualifies init_done; 1 = failed
wr_en  output  1  bus write strobe
rd_en  output  1  bus read strobe
addr  output  4  bus address
wr_data  output  WIDTH  bus write data
rd_data  input  WIDTH  bus read data (combinational from the responder)

Behaviour:
- Reset: async. All outputs go to 0 immediately; the FSM returns to IDLE; any in-flight command or init is dropped with no response and no done pulse.
- Bus outputs are registered.
- Each access asserts exactly one strobe for exactly one cycle.
- rd_data is sampled at the clock edge that ends the rd_en cycle.
- wr_data and addr are 0 when no strobe is active.
- Legal addresses are 0x0, 0x4, 0x8 and 0xC. All other addresses are illegal.
- FSM states: IDLE, BUS, RESP, INIT_SEQ, INIT_END.
- cmd_ready = (state==IDLE) && !init_start.
- Command accepted at cycle N (legal address):
  - N+1: BUS state, strobe asserted.
  - N+2 onward: RESP state, rsp_valid=1 with rsp_rdata captured (reads) or 0 (writes), rsp_err=0.
  - Response is held stable until rsp_valid&&rsp_ready, then the FSM returns to IDLE.
  - Next command can be accepted the cycle after the handshake at the earliest.
- Illegal address: no strobe. RESP is entered at N+1 with rsp_err=1 and rsp_rdata=0.
- init_start in IDLE:
  - Takes priority over cmd_valid in the same cycle.
  - init_start outside IDLE is ignored.
  - init_* values are latched at start cycle S.
- Range check at start: if init_duty > init_period (unsigned), there is no bus activity and init_done=1, init_fail=1 at S+1.
- Otherwise init_busy=1 from S+1 through S+8, with back-to-back strobes:
  - S+1: write 0x0 = 0 (disable)
  - S+2: write 0xC = presc
  - S+3: write 0x4 = period
  - S+4: write 0x8 = duty
  - S+5: read 0x4
  - S+6: read 0x8
  - S+7: read 0xC
  - Each read is compared against its latched value. Any mismatch sets an internal fail flag.
  - S+8: write 0x0 = {0…, init_mode, 1} only if no mismatch; otherwise no strobe.
  - S+9: INIT_END, init_done=1 for one cycle, init_fail = mismatch. Then IDLE.
- rsp_valid is never asserted during init.
- Control write data is zero-extended to WIDTH.

Test Plan:
- Write 0x4=0x03E8 then read 0x4 (rsp_ready=1): wr_en one cycle at N+1 with addr=4, wr_data=0x03E8; read returns rsp_rdata=0x03E8, rsp_err=0, two cycles after acceptance.
- Read 0x6: no wr_en/rd_en activity; rsp_valid at N+1 with rsp_err=1, rsp_rdata=0.
- Read 0x8 with rsp_ready held low 5 cycles: rsp_valid and rsp_rdata stay stable, cmd_ready=0 throughout, and the next command is accepted the cycle after the handshake.
- init_start with period=1000, duty=250, presc=4, mode=1 against a real pwm register model:
  - exact strobe sequence as above, final write 0x0=0x0003;
  - init_done at S+9 with init_fail=0;
  - model shows en=1, mode=1.
- init with duty=1200, period=1000: no strobes, init_done=1 and init_fail=1 at S+1. Also, a responder model that corrupts reads of 0x8: no final 0x0 write, init_fail=1.
- Assert rst_n low at S+5 during init: all outputs 0 asynchronously, no init_done, and after release the module is IDLE with cmd_ready=1.
